// File: rtl/led_pkg.sv
// Shared definitions for the LED fader: FSM encoding and default timing.
package led_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        FADING = 1'b1
    } fader_state_t;

    localparam int NUM_LEDS         = 6;
    localparam int DEFAULT_PWM_BITS = 8;
    localparam int DEFAULT_STEP_DIV = 52734;

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: brightness level that walks toward its target one step at
// a time, compared against the shared PWM counter and registered to the pin.
module led_pwm_channel
    import led_pkg::*;
#(
    parameter int PWM_BITS   = DEFAULT_PWM_BITS,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                step,
    input  logic [PWM_BITS-1:0] target,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic [PWM_BITS-1:0] level,
    output logic                settled_next,
    output logic                led
);

    logic [PWM_BITS-1:0] level_next;

    // Moving only while strictly below/above the target keeps the level
    // inside 0..max without any explicit saturation.
    always_comb begin
        level_next = level;
        if (step) begin
            if (level < target) begin
                level_next = level + PWM_BITS'(1);
            end else if (level > target) begin
                level_next = level - PWM_BITS'(1);
            end
        end
        settled_next = (level_next == target);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level <= '0;
            led   <= ACTIVE_LOW;
        end else begin
            level <= level_next;
            led   <= (level > pwm_cnt) ^ ACTIVE_LOW;
        end
    end

endmodule

// File: rtl/led_fader.sv
// LED fader top: accepts an on/off pattern and fades six PWM-driven LEDs
// toward it, one brightness step every STEP_DIV clocks.
module led_fader
    import led_pkg::*;
#(
    parameter int PWM_BITS   = DEFAULT_PWM_BITS,
    parameter int STEP_DIV   = DEFAULT_STEP_DIV,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_LEDS-1:0]          value_in,
    input  logic                         value_valid,
    output logic                         value_ready,
    output logic                         busy,
    output logic [NUM_LEDS-1:0]          led,
    output fader_state_t                 state_dbg,
    output logic [NUM_LEDS*PWM_BITS-1:0] level_dbg
);

    localparam int                DIV_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(STEP_DIV - 1);

    fader_state_t          state;
    fader_state_t          state_next;
    logic [DIV_W-1:0]      div_cnt;
    logic [PWM_BITS-1:0]   pwm_cnt;
    logic [NUM_LEDS-1:0]   target_bits;
    logic [NUM_LEDS-1:0]   settled_next;
    logic [PWM_BITS-1:0]   level [NUM_LEDS];
    logic                  accept;
    logic                  step_tick;
    logic                  new_differs;

    // Handshake: value_in is taken on an edge where value_valid && value_ready;
    // value_ready is high only in IDLE, and an unaccepted offer is simply lost.
    assign value_ready = (state == IDLE);
    assign busy        = (state == FADING);
    assign accept      = value_valid && value_ready;
    assign step_tick   = (state == FADING) && (div_cnt == DIV_LAST);
    assign state_dbg   = state;

    always_comb begin
        new_differs = 1'b0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (level[i] != {PWM_BITS{value_in[i]}}) begin
                new_differs = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && new_differs) begin
                    state_next = FADING;
                end
            end
            FADING: begin
                if (step_tick && (&settled_next)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The divider only runs while fading; being parked at 0 in IDLE is what
    // makes the first step land exactly STEP_DIV clocks after acceptance.
    always_ff @(posedge clk) begin
        if (rst || (state != FADING) || step_tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt     <= '0;
            target_bits <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            if (accept) begin
                target_bits <= value_in;
            end
        end
    end

    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_chan
        led_pwm_channel #(
            .PWM_BITS   (PWM_BITS),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .step         (step_tick),
            .target       ({PWM_BITS{target_bits[g]}}),
            .pwm_cnt      (pwm_cnt),
            .level        (level[g]),
            .settled_next (settled_next[g]),
            .led          (led[g])
        );
        assign level_dbg[g*PWM_BITS +: PWM_BITS] = level[g];
    end

endmodule

// File: tb/tb_led_fader.sv
// Self-checking bench for led_fader: a time-based model predicts levels,
// handshake, FSM state and LED pins for every cycle after each acceptance.
module tb_led_fader;
    import led_pkg::*;

    localparam int PB   = 4;
    localparam int SD   = 2;
    localparam int NL   = NUM_LEDS;
    localparam bit AL   = 1'b1;
    localparam int MAXL = (1 << PB) - 1;
    localparam int OW   = 3 + NL + NL * PB;

    // Clock / reset block
    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [NL-1:0]    value_in = '0;
    logic             value_valid = 1'b0;
    logic             value_ready;
    logic             busy;
    logic [NL-1:0]    led;
    fader_state_t     state_dbg;
    logic [NL*PB-1:0] level_dbg;
    logic [OW-1:0]    obs;

    int tests_run    = 0;
    int tests_failed = 0;
    int n_edges      = 0;

    // Model record of the latest acceptance: edge index, start/target levels,
    // and how many edges the whole fade lasts.
    int m_n0;
    int m_len;
    int m_start [NL];
    int m_tgt   [NL];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) n_edges <= 0;
        else     n_edges <= n_edges + 1;
    end

    assign obs = {value_ready, busy, state_dbg, led, level_dbg};

    led_fader #(
        .PWM_BITS   (PB),
        .STEP_DIV   (SD),
        .ACTIVE_LOW (AL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .value_in    (value_in),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .busy        (busy),
        .led         (led),
        .state_dbg   (state_dbg),
        .level_dbg   (level_dbg)
    );

    // Reference model
    function automatic int exp_level(input int i, input int n);
        int k;
        int d;
        if (n < m_n0) return m_start[i];
        k = (n - m_n0) / SD;
        d = m_tgt[i] - m_start[i];
        if (d >= 0) return m_start[i] + ((d < k) ? d : k);
        return m_start[i] - ((-d < k) ? -d : k);
    endfunction

    function automatic bit exp_busy(input int n);
        return (n >= m_n0) && ((n - m_n0) < m_len);
    endfunction

    function automatic logic [OW-1:0] exp_obs(input int n);
        logic [NL*PB-1:0] lv;
        logic [NL-1:0]    l;
        bit               bsy;
        fader_state_t     st;
        bsy = exp_busy(n);
        st  = bsy ? FADING : IDLE;
        for (int i = 0; i < NL; i++) begin
            lv[i*PB +: PB] = PB'(exp_level(i, n));
            if (n == 0) l[i] = AL;
            else        l[i] = (exp_level(i, n - 1) > ((n - 1) % (MAXL + 1))) ^ AL;
        end
        return {~bsy, bsy, st, l, lv};
    endfunction

    task automatic model_reset();
        m_n0  = 0;
        m_len = 0;
        for (int i = 0; i < NL; i++) begin
            m_start[i] = 0;
            m_tgt[i]   = 0;
        end
    endtask

    // Driver: offer a pattern for one edge; the model decides if it is taken.
    task automatic offer(input logic [NL-1:0] v);
        int st [NL];
        int mx;
        @(negedge clk);
        if (!exp_busy(n_edges)) begin
            mx = 0;
            for (int i = 0; i < NL; i++) st[i] = exp_level(i, n_edges);
            for (int i = 0; i < NL; i++) begin
                m_start[i] = st[i];
                m_tgt[i]   = v[i] ? MAXL : 0;
                if (m_tgt[i] - st[i] > mx) mx = m_tgt[i] - st[i];
                if (st[i] - m_tgt[i] > mx) mx = st[i] - m_tgt[i];
            end
            m_n0  = n_edges + 1;
            m_len = mx * SD;
        end
        value_valid = 1'b1;
        value_in    = v;
        @(posedge clk);
        #1;
        value_valid = 1'b0;
        value_in    = NL'($urandom_range(0, 63));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        model_reset();
        @(negedge clk);
        tests_run++;
        if (led !== 6'b111111) begin
            tests_failed++;
            $display("FAIL reset_led got=%b exp=%b", led, 6'b111111);
        end
        tests_run++;
        if (value_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_hs got ready=%b busy=%b exp ready=1 busy=0", value_ready, busy);
        end
        tests_run++;
        if (obs !== exp_obs(n_edges)) begin
            tests_failed++;
            $display("FAIL reset_all got=%h exp=%h", obs, exp_obs(n_edges));
        end
        rst = 1'b0;
    endtask

    task automatic test_fade_up();
        offer(6'b000001);
        for (int c = 0; c < 34; c++) begin
            @(negedge clk);
            if (c == 29 || c == 30) begin
                tests_run++;
                if (level_dbg[PB-1:0] !== PB'(c / 2) || busy !== (c == 29)) begin
                    tests_failed++;
                    $display("FAIL fade_up_end c=%0d got lvl=%0d busy=%b exp lvl=%0d busy=%b",
                             c, level_dbg[PB-1:0], busy, c / 2, (c == 29));
                end
            end
            tests_run++;
            if (obs !== exp_obs(n_edges)) begin
                tests_failed++;
                $display("FAIL fade_up n=%0d got=%h exp=%h", n_edges, obs, exp_obs(n_edges));
            end
        end
    endtask

    task automatic test_duty();
        int lows;
        int highs;
        lows = 0;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            if (led[0] == 1'b0) lows++;
            tests_run++;
            if (obs !== exp_obs(n_edges)) begin
                tests_failed++;
                $display("FAIL duty_full n=%0d got=%h exp=%h", n_edges, obs, exp_obs(n_edges));
            end
        end
        tests_run++;
        if (lows != 30) begin
            tests_failed++;
            $display("FAIL duty_lows got=%0d exp=30", lows);
        end
        offer(6'b000000);
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            tests_run++;
            if (obs !== exp_obs(n_edges)) begin
                tests_failed++;
                $display("FAIL fade_down n=%0d got=%h exp=%h", n_edges, obs, exp_obs(n_edges));
            end
        end
        highs = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (led[0] == 1'b1) highs++;
        end
        tests_run++;
        if (highs != 16) begin
            tests_failed++;
            $display("FAIL duty_off got=%0d exp=16", highs);
        end
    endtask

    task automatic test_dropped();
        offer(6'b000001);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            tests_run++;
            if (obs !== exp_obs(n_edges)) begin
                tests_failed++;
                $display("FAIL drop_pre n=%0d got=%h exp=%h", n_edges, obs, exp_obs(n_edges));
            end
        end
        offer(6'b111111);
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            tests_run++;
            if (obs !== exp_obs(n_edges)) begin
                tests_failed++;
                $display("FAIL drop_post n=%0d got=%h exp=%h", n_edges, obs, exp_obs(n_edges));
            end
        end
        tests_run++;
        if (level_dbg !== 24'h00000f) begin
            tests_failed++;
            $display("FAIL drop_levels got=%h exp=%h", level_dbg, 24'h00000f);
        end
        offer(6'b111111);
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL reoffer_busy got=%b exp=1", busy);
        end
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            tests_run++;
            if (obs !== exp_obs(n_edges)) begin
                tests_failed++;
                $display("FAIL reoffer n=%0d got=%h exp=%h", n_edges, obs, exp_obs(n_edges));
            end
        end
    endtask

    task automatic test_noop();
        offer(6'b000000);
        repeat (32) @(negedge clk);
        offer(6'b000000);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            tests_run++;
            if (busy !== 1'b0 || value_ready !== 1'b1 || state_dbg !== IDLE) begin
                tests_failed++;
                $display("FAIL noop c=%0d got busy=%b ready=%b exp busy=0 ready=1", c, busy, value_ready);
            end
            tests_run++;
            if (obs !== exp_obs(n_edges)) begin
                tests_failed++;
                $display("FAIL noop_all n=%0d got=%h exp=%h", n_edges, obs, exp_obs(n_edges));
            end
        end
    endtask

    task automatic test_reset_mid_fade();
        offer(6'b000001);
        repeat (14) @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (level_dbg[PB-1:0] !== PB'(7)) begin
            tests_failed++;
            $display("FAIL midrst_pre got=%0d exp=7", level_dbg[PB-1:0]);
        end
        rst = 1'b1;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if (level_dbg !== '0 || led !== 6'b111111 || state_dbg !== IDLE) begin
            tests_failed++;
            $display("FAIL midrst got lvl=%h led=%b st=%0d exp lvl=0 led=111111 st=0",
                     level_dbg, led, state_dbg);
        end
        tests_run++;
        if (obs !== exp_obs(n_edges)) begin
            tests_failed++;
            $display("FAIL midrst_all got=%h exp=%h", obs, exp_obs(n_edges));
        end
    endtask

    task automatic test_random();
        int gap;
        for (int r = 0; r < 10; r++) begin
            offer(NL'($urandom_range(0, 63)));
            gap = $urandom_range(3, 70);
            for (int c = 0; c < gap; c++) begin
                @(negedge clk);
                tests_run++;
                if (obs !== exp_obs(n_edges)) begin
                    tests_failed++;
                    $display("FAIL random r=%0d n=%0d got=%h exp=%h", r, n_edges, obs, exp_obs(n_edges));
                end
            end
        end
        for (int c = 0; c < 36; c++) begin
            @(negedge clk);
            tests_run++;
            if (obs !== exp_obs(n_edges)) begin
                tests_failed++;
                $display("FAIL random_tail n=%0d got=%h exp=%h", n_edges, obs, exp_obs(n_edges));
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fade_up();
        test_duty();
        test_dropped();
        test_noop();
        test_reset_mid_fade();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
